uart_tx_arbiter: RTL and testbench

Round-robin, packet-locked arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte-stream requesters. A granted requester holds the transmitter until it sends a byte flagged `last`, or until it stalls past `TIMEOUT_CYCLES`. The block sits between on-chip clients (e.g. status reporter, command responder, debug dump) and the single `uart_tx` instance. It sequences every byte handoff against the `uart_tx_busy` handshake.

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_tx_arbiter_rr_pick.sv | 14 +
 rtl/uart_tx_arbiter.sv | 109 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and limits for the UART transmit arbiter.
package uart_pkg;
  typedef enum logic [1:0] {ARB, SEND, ISSUE, DRAIN} uart_arb_state_t;
  localparam int UART_ARB_MAX_REQ = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: one-hot round-robin pick, scanning upward from the bit after the one-hot last_grant.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last_grant,
  output logic [NUM_REQ-1:0] pick
);
  logic [NUM_REQ-1:0] upper, pool;
  // Requests strictly above last_grant win; otherwise wrap to the lowest request.
  assign upper = req & ~(last_grant | (last_grant - 1'b1));
  assign pool  = (|upper) ? upper : req;
  assign pick  = pool & (~pool + 1'b1);
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one uart_tx between NUM_REQ byte streams,
// with a stall timeout that revokes a grant whose owner stops supplying bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 8680
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 pkt_abort,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_busy
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  uart_arb_state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, last_grant_q, last_grant_d, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d, sel_data;
  logic last_q, last_d, abort_q, abort_d, sel_last, accept, timeout;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .pick      (pick)
  );
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
  end
  assign req_ready    = (state_q == SEND && !uart_tx_busy) ? (grant_q & req_valid) : '0;
  assign accept       = |req_ready;
  assign timeout      = TIMEOUT_CYCLES != 0 && int'(cnt_q) + 1 == TIMEOUT_CYCLES;
  assign grant        = grant_q;
  assign pkt_abort    = abort_q;
  assign uart_tx_en   = state_q == ISSUE;
  assign uart_tx_data = data_q;
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    last_d       = last_q;
    abort_d      = 1'b0;
    case (state_q)
      ARB:
        if (|req_valid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = SEND;
        end
      SEND:
        if (accept) begin
          data_d  = sel_data;
          last_d  = sel_last;
          state_d = ISSUE;
        end else if (timeout) begin
          abort_d      = 1'b1;
          last_grant_d = grant_q;
          grant_d      = '0;
          state_d      = ARB;
        end else begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
      ISSUE: state_d = DRAIN;
      DRAIN:
        if (!uart_tx_busy) begin
          if (last_q) begin
            last_grant_d = grant_q;
            grant_d      = '0;
            state_d      = ARB;
          end else begin
            cnt_d   = '0;
            state_d = SEND;
          end
        end
      default: state_d = ARB;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q      <= ARB;
      grant_q      <= '0;
      last_grant_q <= {1'b1, {(NUM_REQ-1){1'b0}}};
      cnt_q        <= '0;
      data_q       <= 8'h00;
      last_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      last_q       <= last_d;
      abort_q      <= abort_d;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scenario bench with a uart_tx busy model and a round-robin reference model.
module tb_uart_tx_arbiter;
  localparam int N = 4, TO = 8680, CHAR = 4340;
  logic clk = 1'b0, resetn = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [8*N-1:0] req_data = '0;
  logic pkt_abort, uart_tx_en, uart_tx_busy;
  logic [7:0] uart_tx_data;
  int compared = 0, mismatched = 0;
  int cyc = 0, busy_cnt = 0, model_last = N - 1;
  logic busy_hold = 1'b0, ready_bad = 1'b0, en_bad = 1'b0;
  logic [8:0] mem [N][64];
  int head [N] = '{default: 0};
  int tail [N] = '{default: 0};
  logic [N-1:0] rdy_s = '0, prev_grant = '0;
  logic [7:0] tx_log [$];
  int grant_log [$];

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .pkt_abort(pkt_abort), .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_tx_en) busy_cnt <= CHAR;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = busy_cnt != 0 || busy_hold;

  always @(negedge clk) begin
    rdy_s = req_ready;
    if (uart_tx_en) begin
      tx_log.push_back(uart_tx_data);
      if (uart_tx_busy) en_bad = 1'b1;
    end
    if ((req_ready & ~grant) != 0 || $countones(req_ready) > 1) ready_bad = 1'b1;
    if (grant != 0 && prev_grant == 0)
      for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
    prev_grant = grant;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) if (rdy_s[i] && head[i] != tail[i]) head[i] = head[i] + 1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = head[i] != tail[i];
      {req_last[i], req_data[8*i +: 8]} = (head[i] != tail[i]) ? mem[i][head[i] % 64] : 9'h0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][tail[r] % 64] = {l, d};
    tail[r] = tail[r] + 1;
  endtask

  function automatic int rr_next(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic wait_busy_low(input string name);
    int n;
    for (n = 0; n < CHAR + 50 && uart_tx_busy; n++) tick();
    compared++;
    if (uart_tx_busy) begin
      mismatched++;
      $display("FAIL %s: busy still high after %0d cycles, required low", name, n);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    compared += 5;
    if (grant !== '0) begin mismatched++; $display("FAIL reset_grant: got %b required 0", grant); end
    if (req_ready !== '0) begin mismatched++; $display("FAIL reset_ready: got %b required 0", req_ready); end
    if (pkt_abort !== 1'b0) begin mismatched++; $display("FAIL reset_abort: got %b required 0", pkt_abort); end
    if (uart_tx_en !== 1'b0) begin mismatched++; $display("FAIL reset_en: got %b required 0", uart_tx_en); end
    if (uart_tx_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h required 00", uart_tx_data); end
    resetn = 1'b1;
    model_last = N - 1;
    tick();
  endtask

  task automatic test_single_byte();
    push(2, 8'hA5, 1'b1);
    tick();
    tick();
    compared += 2;
    if (grant !== 4'b0100) begin mismatched++; $display("FAIL single_grant: got %b required 0100", grant); end
    if (req_ready !== 4'b0100) begin mismatched++; $display("FAIL single_ready: got %b required 0100", req_ready); end
    tick();
    compared++;
    if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'hA5) begin
      mismatched++;
      $display("FAIL single_issue: en=%b data=%h required en=1 data=a5", uart_tx_en, uart_tx_data);
    end
    tick();
    compared++;
    if (uart_tx_en !== 1'b0) begin mismatched++; $display("FAIL single_en_once: got %b required 0", uart_tx_en); end
    wait_busy_low("single_drain");
    compared++;
    if (grant !== 4'b0100) begin mismatched++; $display("FAIL single_hold: got %b required 0100", grant); end
    tick();
    compared++;
    if (grant !== '0) begin mismatched++; $display("FAIL single_release: got %b required 0", grant); end
    model_last = 2;
  endtask

  task automatic test_packet_lock();
    logic [7:0] exp [4];
    int base, n;
    exp = '{8'h11, 8'h22, 8'h33, 8'($urandom)};
    base = tx_log.size();
    push(1, exp[0], 1'b0);
    push(1, exp[1], 1'b0);
    push(1, exp[2], 1'b1);
    for (n = 0; n < 10 && grant == 0; n++) tick();
    compared++;
    if (grant !== 4'b0010) begin mismatched++; $display("FAIL lock_grant1: got %b required 0010", grant); end
    push(0, exp[3], 1'b1);
    for (n = 0; n < 4 * (CHAR + 20) && tx_log.size() < base + 4; n++) tick();
    compared++;
    if (tx_log.size() != base + 4) begin
      mismatched++;
      $display("FAIL lock_count: got %0d bytes required 4", tx_log.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (base + i >= tx_log.size() || tx_log[base + i] !== exp[i]) begin
        mismatched++;
        $display("FAIL lock_byte%0d: got %h required %h", i,
                 (base + i < tx_log.size()) ? tx_log[base + i] : 8'hxx, exp[i]);
      end
    end
    tick();
    wait_busy_low("lock_drain");
    tick();
    model_last = 0;
  endtask

  task automatic test_backpressure();
    int r, w;
    logic [7:0] d;
    logic bad;
    r = $urandom_range(0, N - 1);
    d = 8'($urandom);
    w = rr_next(N'(1) << r, model_last);
    busy_hold = 1'b1;
    push(r, d, 1'b1);
    tick();
    tick();
    compared++;
    if (grant !== (N'(1) << w)) begin mismatched++; $display("FAIL bp_grant: got %b required %b", grant, N'(1) << w); end
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (req_ready != 0 || uart_tx_en) bad = 1'b1;
    end
    compared++;
    if (bad !== 1'b0) begin mismatched++; $display("FAIL bp_hold: got ready/en activity=1 required 0"); end
    busy_hold = 1'b0;
    #1;
    compared++;
    if (req_ready !== (N'(1) << w)) begin mismatched++; $display("FAIL bp_ready: got %b required %b", req_ready, N'(1) << w); end
    tick();
    compared++;
    if (uart_tx_en !== 1'b1 || uart_tx_data !== d) begin
      mismatched++;
      $display("FAIL bp_issue: en=%b data=%h required en=1 data=%h", uart_tx_en, uart_tx_data, d);
    end
    tick();
    wait_busy_low("bp_drain");
    tick();
    model_last = w;
  endtask

  task automatic test_round_robin();
    logic [7:0] b [N][2];
    int cnt [N] = '{2, 2, 1, 1};
    int used [N] = '{default: 0};
    int exp_g [6];
    logic [7:0] exp_b [6];
    logic [N-1:0] mask;
    int last, gbase, tbase, n;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    model_last = N - 1;
    tick();
    gbase = grant_log.size();
    tbase = tx_log.size();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < cnt[r]; k++) begin
        b[r][k] = 8'($urandom);
        push(r, b[r][k], 1'b1);
      end
    last = model_last;
    for (int s = 0; s < 6; s++) begin
      for (int r = 0; r < N; r++) mask[r] = used[r] < cnt[r];
      exp_g[s] = rr_next(mask, last);
      exp_b[s] = b[exp_g[s]][used[exp_g[s]]];
      used[exp_g[s]]++;
      last = exp_g[s];
    end
    for (n = 0; n < 6 * (CHAR + 20) && tx_log.size() < tbase + 6; n++) tick();
    for (int s = 0; s < 6; s++) begin
      compared += 2;
      if (gbase + s >= grant_log.size() || grant_log[gbase + s] != exp_g[s]) begin
        mismatched++;
        $display("FAIL rr_grant%0d: got %0d required %0d", s,
                 (gbase + s < grant_log.size()) ? grant_log[gbase + s] : -1, exp_g[s]);
      end
      if (tbase + s >= tx_log.size() || tx_log[tbase + s] !== exp_b[s]) begin
        mismatched++;
        $display("FAIL rr_byte%0d: got %h required %h", s,
                 (tbase + s < tx_log.size()) ? tx_log[tbase + s] : 8'hxx, exp_b[s]);
      end
    end
    tick();
    wait_busy_low("rr_drain");
    tick();
    model_last = last;
  endtask

  task automatic test_timeout();
    int n, b, w, r;
    push(3, 8'($urandom), 1'b0);
    for (n = 0; n < 10 && grant == 0; n++) tick();
    compared++;
    if (grant !== 4'b1000) begin mismatched++; $display("FAIL to_grant: got %b required 1000", grant); end
    for (n = 0; n < 10 && !uart_tx_en; n++) tick();
    tick();
    wait_busy_low("to_drain");
    b = cyc;
    for (n = 0; n < TO + 20 && !pkt_abort; n++) tick();
    compared += 2;
    if (!pkt_abort || cyc != b + 1 + TO) begin
      mismatched++;
      $display("FAIL to_abort_time: abort=%b at +%0d cycles required 1 at +%0d", pkt_abort, cyc - b, 1 + TO);
    end
    if (grant !== '0) begin mismatched++; $display("FAIL to_release: got %b required 0", grant); end
    model_last = 3;
    r = $urandom_range(1, 2);
    push(0, 8'($urandom), 1'b1);
    push(r, 8'($urandom), 1'b1);
    w = rr_next(4'b0001 | (N'(1) << r), model_last);
    tick();
    compared++;
    if (pkt_abort !== 1'b0) begin mismatched++; $display("FAIL to_pulse_width: got %b required 0", pkt_abort); end
    for (n = 0; n < 10 && grant == 0; n++) tick();
    compared++;
    if (grant !== (N'(1) << w)) begin mismatched++; $display("FAIL to_next: got %b required %b", grant, N'(1) << w); end
  endtask

  task automatic test_reset_mid();
    int r, n, base, w;
    for (int i = 0; i < N; i++) tail[i] = head[i];
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    model_last = N - 1;
    tick();
    r = $urandom_range(1, N - 1);
    base = tx_log.size();
    push(r, 8'($urandom), 1'b0);
    push(r, 8'($urandom), 1'b0);
    push(r, 8'($urandom), 1'b1);
    for (n = 0; n < 2 * (CHAR + 20) && tx_log.size() == base; n++) tick();
    push(0, 8'($urandom), 1'b1);
    repeat (50) tick();
    resetn = 1'b0;
    #1;
    compared += 5;
    if (grant !== '0) begin mismatched++; $display("FAIL mid_grant: got %b required 0", grant); end
    if (req_ready !== '0) begin mismatched++; $display("FAIL mid_ready: got %b required 0", req_ready); end
    if (uart_tx_en !== 1'b0) begin mismatched++; $display("FAIL mid_en: got %b required 0", uart_tx_en); end
    if (pkt_abort !== 1'b0) begin mismatched++; $display("FAIL mid_abort: got %b required 0", pkt_abort); end
    if (uart_tx_data !== 8'h00) begin mismatched++; $display("FAIL mid_data: got %h required 00", uart_tx_data); end
    tick();
    tick();
    resetn = 1'b1;
    w = rr_next(4'b0001 | (N'(1) << r), model_last);
    for (n = 0; n < 10 && grant == 0; n++) tick();
    compared++;
    if (grant !== (N'(1) << w)) begin mismatched++; $display("FAIL mid_rearb: got %b required %b", grant, N'(1) << w); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_packet_lock();
    test_backpressure();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    compared += 2;
    if (ready_bad) begin mismatched++; $display("FAIL ready_onehot_granted: got violation=1 required 0"); end
    if (en_bad) begin mismatched++; $display("FAIL en_while_busy: got violation=1 required 0"); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
